// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program sequencer for the single-cycle I-format CPU. Owns the
//            architectural PC and runs, single-steps, pauses and stops the
//            program. While the program is not executing, the CPU is parked
//            on a side-effect-free instruction.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PARK_ADDR = 32'h0000_03FC,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [CNT_W-1:0] max_instr,
    input  logic [31:0]      next_addr,
    output logic [31:0]      pc_out,
    output logic             commit,
    output logic [31:0]      pc,
    output logic [2:0]       state,
    output logic [1:0]       stop_cause,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] c_cause_none = 2'b00;
    localparam logic [1:0] c_cause_halt = 2'b01;
    localparam logic [1:0] c_cause_bp   = 2'b10;
    localparam logic [1:0] c_cause_eop  = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_exec;
    logic [CNT_W:0]   w_count_inc;
    logic [CNT_W-1:0] w_count_sat;
    logic             w_limit_hit;
    logic             w_self_loop;
    logic             w_eop;
    logic             w_bp_hit;

    // The CPU executes only in RUN/STEP; reset suppresses the execution cycle
    // so no register or memory write lands while the sequencer is resetting.
    assign w_exec = (r_state == S_RUN) || (r_state == S_STEP);
    assign commit = w_exec && !rst;
    assign pc_out = commit ? r_pc : PARK_ADDR;

    // One extra bit keeps the limit compare from wrapping at saturation.
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_count_sat = (&r_count) ? r_count : w_count_inc[CNT_W-1:0];

    assign w_limit_hit = (max_instr != '0) && (w_count_inc == {1'b0, max_instr});
    assign w_self_loop = (next_addr == r_pc);
    assign w_eop       = w_limit_hit || w_self_loop;
    assign w_bp_hit    = bp_en && (next_addr == bp_addr);

    assign pc          = r_pc;
    assign state       = r_state;
    assign stop_cause  = r_cause;
    assign instr_count = r_count;

    // Next-state, next-PC, counter and stop-cause decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_cause_nxt = r_cause;
        case (r_state)
            S_IDLE, S_PAUSED: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cause_nxt = c_cause_none;
                end else if (step) begin
                    w_state_nxt = S_STEP;
                    w_cause_nxt = c_cause_none;
                end
            end
            S_RUN: begin
                // Current instruction always commits; decide where to stop.
                w_pc_nxt    = next_addr;
                w_count_nxt = w_count_sat;
                if (w_eop) begin
                    w_state_nxt = S_DONE;
                    w_cause_nxt = c_cause_eop;
                end else if (halt_req) begin
                    w_state_nxt = S_PAUSED;
                    w_cause_nxt = c_cause_halt;
                end else if (w_bp_hit) begin
                    w_state_nxt = S_PAUSED;
                    w_cause_nxt = c_cause_bp;
                end
            end
            S_STEP: begin
                // Breakpoint ignored here so a step can move off it.
                w_pc_nxt    = next_addr;
                w_count_nxt = w_count_sat;
                if (w_eop) begin
                    w_state_nxt = S_DONE;
                    w_cause_nxt = c_cause_eop;
                end else begin
                    w_state_nxt = S_PAUSED;
                    w_cause_nxt = c_cause_halt;
                end
            end
            S_DONE: begin
                // Restart from the top of the program with a fresh count.
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = RESET_PC;
                    w_count_nxt = '0;
                    w_cause_nxt = c_cause_none;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_cause <= c_cause_none;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            r_cause <= w_cause_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with a behavioural model
//            and a simple CPU stand-in that returns pc+4 (or a self-loop).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          CW = 4;
    localparam logic [31:0] RP = 32'h0000_0000;
    localparam logic [31:0] PA = 32'h0000_03FC;

    logic          clk;
    logic          rst;
    logic          start;
    logic          step;
    logic          halt_req;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic [CW-1:0] max_instr;
    logic [31:0]   next_addr;
    logic [31:0]   pc_out;
    logic          commit;
    logic [31:0]   pc;
    logic [2:0]    state;
    logic [1:0]    stop_cause;
    logic [CW-1:0] instr_count;

    pc_sequencer #(
        .RESET_PC (RP),
        .PARK_ADDR(PA),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .max_instr  (max_instr),
        .next_addr  (next_addr),
        .pc_out     (pc_out),
        .commit     (commit),
        .pc         (pc),
        .state      (state),
        .stop_cause (stop_cause),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU stand-in: sequential fetch, or a branch-to-self at loop_addr.
    bit          loop_en;
    logic [31:0] loop_addr;

    function automatic logic [31:0] cpu_next(input logic [31:0] p, input bit le,
                                             input logic [31:0] la);
        return (le && p == la) ? p : p + 32'd4;
    endfunction

    always_comb next_addr = cpu_next(pc_out, loop_en, loop_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes 0 idle, 1 run, 2 step, 3 paused, 4 done.
    int          m_mode;
    logic [31:0] m_pc;
    int          m_count;
    int          m_cause;
    bit          m_valid = 1'b0;
    logic [31:0] m_nx;
    bit          m_end;
    bit          m_was_step;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pc = RP; m_count = 0; m_cause = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_mode == 1 || m_mode == 2) begin
                m_nx       = cpu_next(m_pc, loop_en, loop_addr);
                m_end      = (max_instr != 0 && m_count + 1 == int'(max_instr)) || (m_nx == m_pc);
                m_was_step = (m_mode == 2);
                m_pc       = m_nx;
                if (m_count < (1 << CW) - 1) m_count = m_count + 1;
                if (m_end) begin
                    m_mode = 4; m_cause = 3;
                end else if (m_was_step || halt_req) begin
                    m_mode = 3; m_cause = 1;
                end else if (bp_en && m_nx == bp_addr) begin
                    m_mode = 3; m_cause = 2;
                end
            end else if (m_mode == 4) begin
                if (start) begin
                    m_mode = 1; m_pc = RP; m_count = 0; m_cause = 0;
                end
            end else if (start) begin
                m_mode = 1; m_cause = 0;
            end else if (step) begin
                m_mode = 2; m_cause = 0;
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", {29'd0, state}, m_mode);
            chk("pc", pc, m_pc);
            chk("instr_count", {{(32-CW){1'b0}}, instr_count}, m_count);
            chk("stop_cause", {30'd0, stop_cause}, m_cause);
            chk("commit", {31'd0, commit}, {31'd0, (m_mode == 1 || m_mode == 2) && !rst});
            chk("pc_out", pc_out, ((m_mode == 1 || m_mode == 2) && !rst) ? m_pc : PA);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(1); rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(1); step = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; max_instr = '0;
        loop_en = 1'b0; loop_addr = 32'h0;
        cyc(2);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, RP);
        chk("rst_count", {28'd0, instr_count}, 32'd0);
        chk("rst_cause", {30'd0, stop_cause}, 32'd0);
        chk("rst_commit", {31'd0, commit}, 32'd0);
        chk("rst_pc_out", pc_out, PA);
        rst = 1'b0;

        // halt_req in IDLE has no effect
        halt_req = 1'b1; cyc(2); halt_req = 1'b0;
        chk("idle_halt_state", {29'd0, state}, 32'd0);

        // Free run, ignored start/step, counter saturation, then halt
        pulse_start();
        chk("start_commit", {31'd0, commit}, 32'd1);
        chk("start_pc_out", pc_out, 32'h0);
        cyc(3);
        start = 1'b1; step = 1'b1; cyc(1); start = 1'b0; step = 1'b0;
        chk("run_ignore_pc", pc, 32'h10);
        cyc(16);
        chk("sat_count", {28'd0, instr_count}, 32'd15);
        chk("sat_pc", pc, 32'h50);
        halt_req = 1'b1; cyc(1); halt_req = 1'b0;
        chk("halt_state", {29'd0, state}, 32'd3);
        chk("halt_pc", pc, 32'h54);
        chk("halt_cause", {30'd0, stop_cause}, 32'd1);
        chk("halt_commit", {31'd0, commit}, 32'd0);

        // Instruction limit, step ignored in DONE, restart
        do_reset();
        max_instr = 4'd5;
        pulse_start();
        cyc(6);
        chk("lim_state", {29'd0, state}, 32'd4);
        chk("lim_cause", {30'd0, stop_cause}, 32'd3);
        chk("lim_pc", pc, 32'h14);
        chk("lim_count", {28'd0, instr_count}, 32'd5);
        pulse_step();
        chk("done_step_state", {29'd0, state}, 32'd4);
        pulse_start();
        chk("restart_pc", pc, 32'h0);
        chk("restart_count", {28'd0, instr_count}, 32'd0);
        chk("restart_state", {29'd0, state}, 32'd1);
        cyc(6);
        chk("lim2_pc", pc, 32'h14);
        max_instr = '0;

        // Breakpoint, then step off it
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10;
        pulse_start();
        cyc(8);
        chk("bp_state", {29'd0, state}, 32'd3);
        chk("bp_pc", pc, 32'h10);
        chk("bp_cause", {30'd0, stop_cause}, 32'd2);
        chk("bp_count", {28'd0, instr_count}, 32'd4);
        pulse_step();
        chk("step_commit", {31'd0, commit}, 32'd1);
        cyc(1);
        chk("step_pc", pc, 32'h14);
        chk("step_cause", {30'd0, stop_cause}, 32'd1);
        cyc(2);
        chk("step_once", {31'd0, commit}, 32'd0);

        // Halt and breakpoint on the same edge: halt wins
        do_reset();
        pulse_start();
        cyc(3);
        halt_req = 1'b1; cyc(1); halt_req = 1'b0;
        chk("hbp_pc", pc, 32'h10);
        chk("hbp_cause", {30'd0, stop_cause}, 32'd1);
        bp_en = 1'b0;

        // start+step together, then self-loop end of program
        do_reset();
        loop_en = 1'b1; loop_addr = 32'h8;
        start = 1'b1; step = 1'b1; cyc(1); start = 1'b0; step = 1'b0;
        chk("both_state", {29'd0, state}, 32'd1);
        cyc(4);
        chk("loop_state", {29'd0, state}, 32'd4);
        chk("loop_cause", {30'd0, stop_cause}, 32'd3);
        chk("loop_pc", pc, 32'h8);
        chk("loop_count", {28'd0, instr_count}, 32'd3);
        loop_en = 1'b0;

        // Step from IDLE, then end of program during a step
        do_reset();
        pulse_step();
        cyc(1);
        chk("istep_pc", pc, 32'h4);
        chk("istep_cause", {30'd0, stop_cause}, 32'd1);
        max_instr = 4'd2;
        pulse_step();
        cyc(1);
        chk("eopstep_state", {29'd0, state}, 32'd4);
        chk("eopstep_cause", {30'd0, stop_cause}, 32'd3);
        chk("eopstep_pc", pc, 32'h8);
        max_instr = '0;

        // Reset mid-run
        do_reset();
        pulse_start();
        cyc(3);
        rst = 1'b1;
        #1;
        chk("midrst_commit", {31'd0, commit}, 32'd0);
        chk("midrst_pc_out", pc_out, PA);
        cyc(1);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_pc", pc, RP);
        chk("midrst_count", {28'd0, instr_count}, 32'd0);
        rst = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
